// File: rtl/mul_pkg.sv
// Shared types and default sizing for the multiply-accumulate stage.
// Sizing defaults mirror the upstream 6-bit array multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } acc_state_t;

    localparam int DEF_WIDTH     = 6;
    localparam int DEF_MAX_TERMS = 16;
    localparam int PROD_WIDTH    = 2 * DEF_WIDTH;
    localparam int CNT_WIDTH     = $clog2(DEF_MAX_TERMS) + 1;
    localparam int DEF_ACC_WIDTH = PROD_WIDTH + $clog2(DEF_MAX_TERMS);

    function automatic int prod_width(input int w);
        return 2 * w;
    endfunction

endpackage

// File: rtl/mul_acc_reg.sv
// Accumulator register with synchronous clear and add-enable.
// Define MUL_ACC_SAT_EN to saturate each addition and expose a sticky o_ovf flag.
module mul_acc_reg #(
    parameter int prod_w    = 12,
    parameter int acc_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_clear,
    input  logic                 i_addEn,
    input  logic [prod_w-1:0]    i_addend,
`ifdef MUL_ACC_SAT_EN
    output logic                 o_ovf,
`endif
    output logic [acc_width-1:0] o_acc
);

    logic [acc_width-1:0] r_acc;

`ifdef MUL_ACC_SAT_EN
    logic                 r_ovf;
    logic [acc_width:0]   w_sum;

    // One extra bit catches the carry-out that triggers saturation.
    assign w_sum = {1'b0, r_acc} + (acc_width + 1)'(i_addend);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_clear) begin
            r_acc <= '0;
            r_ovf <= 1'b0;
        end else if (i_addEn) begin
            if (w_sum[acc_width]) begin
                r_acc <= '1;
                r_ovf <= 1'b1;
            end else begin
                r_acc <= w_sum[acc_width-1:0];
            end
        end
    end

    assign o_ovf = r_ovf;
`else
    logic [acc_width-1:0] w_sum;

    assign w_sum = r_acc + acc_width'(i_addend);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_addEn) begin
            r_acc <= w_sum;
        end
    end
`endif

    assign o_acc = r_acc;

endmodule

// File: rtl/mul_acc_unit.sv
// Dot-product accumulator behind the array multiplier: sums len products, then offers the result.
// Optional macro MUL_ACC_SAT_EN enables saturating adds and the ovf output.
module mul_acc_unit
    import mul_pkg::*;
#(
    parameter int width     = DEF_WIDTH,
    parameter int max_terms = DEF_MAX_TERMS,
    parameter int acc_width = prod_width(width) + $clog2(max_terms)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(max_terms):0]   len,
    input  logic                         prod_valid,
    input  logic [prod_width(width)-1:0] prod_data,
    output logic                         prod_ready,
    output logic                         acc_valid,
    output logic [acc_width-1:0]         acc_data,
    input  logic                         acc_ready,
`ifdef MUL_ACC_SAT_EN
    output logic                         ovf,
`endif
    output logic                         busy,
    output logic [$clog2(max_terms):0]   term_cnt
);

    localparam int CNT_W = $clog2(max_terms) + 1;
    localparam logic [CNT_W-1:0] MAX_LEN = CNT_W'(max_terms);

    acc_state_t       r_state;
    acc_state_t       w_nextState;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_termCnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_lenOk;
    logic             w_startAcc;
    logic             w_accept;

    assign w_lenOk    = (len != '0) && (len <= MAX_LEN);
    // A new run may begin from IDLE, or from DONE in the same cycle the result is taken.
    assign w_startAcc = start && w_lenOk &&
                        ((r_state == IDLE) || ((r_state == DONE) && acc_ready));
    assign w_accept   = prod_valid && (r_state == ACC);
    assign w_cntNext  = r_termCnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_startAcc) begin
                    w_nextState = ACC;
                end
            end
            ACC: begin
                if (w_accept && (w_cntNext == r_len)) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                if (acc_ready) begin
                    w_nextState = w_startAcc ? ACC : IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len     <= '0;
            r_termCnt <= '0;
        end else if (w_startAcc) begin
            r_len     <= len;
            r_termCnt <= '0;
        end else if (w_accept) begin
            r_termCnt <= w_cntNext;
        end
    end

    mul_acc_reg #(
        .prod_w    (prod_width(width)),
        .acc_width (acc_width)
    ) u_accReg (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_startAcc),
        .i_addEn  (w_accept),
        .i_addend (prod_data),
`ifdef MUL_ACC_SAT_EN
        .o_ovf    (ovf),
`endif
        .o_acc    (acc_data)
    );

    assign prod_ready = (r_state == ACC);
    assign acc_valid  = (r_state == DONE);
    assign busy       = (r_state != IDLE);
    assign term_cnt   = r_termCnt;

endmodule

// File: tb/tb_mul_acc_unit.sv
// Directed self-checking bench for mul_acc_unit (default sizing plus a narrow acc_width=12 instance).
// Honours MUL_ACC_SAT_EN for the ovf port and the saturation expectations.
module tb_mul_acc_unit;

    logic        clk;
    logic        rst;

    logic        start;
    logic [4:0]  len;
    logic        prod_valid;
    logic [11:0] prod_data;
    logic        prod_ready;
    logic        acc_valid;
    logic [15:0] acc_data;
    logic        acc_ready;
    logic        busy;
    logic [4:0]  term_cnt;

    logic        nStart;
    logic [4:0]  nLen;
    logic        nProdValid;
    logic [11:0] nProdData;
    logic        nProdReady;
    logic        nAccValid;
    logic [11:0] nAccData;
    logic        nAccReady;
    logic        nBusy;
    logic [4:0]  nTermCnt;

`ifdef MUL_ACC_SAT_EN
    logic        ovf;
    logic        nOvf;
`endif

    int nCompared;
    int nMismatched;

    mul_acc_unit u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .len        (len),
        .prod_valid (prod_valid),
        .prod_data  (prod_data),
        .prod_ready (prod_ready),
        .acc_valid  (acc_valid),
        .acc_data   (acc_data),
        .acc_ready  (acc_ready),
`ifdef MUL_ACC_SAT_EN
        .ovf        (ovf),
`endif
        .busy       (busy),
        .term_cnt   (term_cnt)
    );

    mul_acc_unit #(.width(6), .max_terms(16), .acc_width(12)) u_dutNarrow (
        .clk        (clk),
        .rst        (rst),
        .start      (nStart),
        .len        (nLen),
        .prod_valid (nProdValid),
        .prod_data  (nProdData),
        .prod_ready (nProdReady),
        .acc_valid  (nAccValid),
        .acc_data   (nAccData),
        .acc_ready  (nAccReady),
`ifdef MUL_ACC_SAT_EN
        .ovf        (nOvf),
`endif
        .busy       (nBusy),
        .term_cnt   (nTermCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [4:0] l, input logic pv,
                                 input logic [11:0] pd, input logic ar);
        start      = s;
        len        = l;
        prod_valid = pv;
        prod_data  = pd;
        acc_ready  = ar;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        applyStimulus(1'b0, 5'd0, 1'b0, 12'd0, 1'b0);
        nStart = 1'b0; nLen = 5'd0; nProdValid = 1'b0; nProdData = 12'd0; nAccReady = 1'b0;
        tick();
        tick();
        nCompared++; if (acc_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_acc_valid got=%b want=0", acc_valid); end
        nCompared++; if (prod_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_prod_ready got=%b want=0", prod_ready); end
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
        nCompared++; if (term_cnt !== 5'd0) begin nMismatched++; $display("[TB] FAIL reset_term_cnt got=%0d want=0", term_cnt); end
        nCompared++; if (acc_data !== 16'd0) begin nMismatched++; $display("[TB] FAIL reset_acc_data got=%0d want=0", acc_data); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_continuous();
        int readyCycles;
        readyCycles = 0;
        applyStimulus(1'b1, 5'd4, 1'b0, 12'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd4, 1'b1, 12'd3969, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (prod_ready === 1'b1) readyCycles++;
            tick();
        end
        prod_valid = 1'b0;
        nCompared++; if (readyCycles != 4) begin nMismatched++; $display("[TB] FAIL cont_ready_cycles got=%0d want=4", readyCycles); end
        nCompared++; if (acc_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL cont_acc_valid got=%b want=1", acc_valid); end
        nCompared++; if (acc_data !== 16'd15876) begin nMismatched++; $display("[TB] FAIL cont_acc_data got=%0d want=15876", acc_data); end
        nCompared++; if (term_cnt !== 5'd4) begin nMismatched++; $display("[TB] FAIL cont_term_cnt got=%0d want=4", term_cnt); end
        nCompared++; if (prod_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL cont_done_prod_ready got=%b want=0", prod_ready); end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        nCompared++; if (acc_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL cont_after_hs_valid got=%b want=0", acc_valid); end
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL cont_after_hs_busy got=%b want=0", busy); end
        nCompared++; if (acc_data !== 16'd15876) begin nMismatched++; $display("[TB] FAIL cont_hold_acc_data got=%0d want=15876", acc_data); end
    endtask

    task automatic test_gaps_backpressure();
        applyStimulus(1'b1, 5'd3, 1'b0, 12'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd3, 1'b1, 12'd10, 1'b0);
        tick();
        prod_valid = 1'b0;
        tick();
        tick();
        nCompared++; if (term_cnt !== 5'd1) begin nMismatched++; $display("[TB] FAIL gap_term_cnt got=%0d want=1", term_cnt); end
        nCompared++; if (prod_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL gap_prod_ready got=%b want=1", prod_ready); end
        prod_valid = 1'b1; prod_data = 12'd0;
        tick();
        prod_valid = 1'b0;
        tick();
        tick();
        prod_valid = 1'b1; prod_data = 12'd20;
        tick();
        prod_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            start = (i == 2);
            len   = 5'd2;
            nCompared++; if (acc_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL bp_acc_valid[%0d] got=%b want=1", i, acc_valid); end
            nCompared++; if (acc_data !== 16'd30) begin nMismatched++; $display("[TB] FAIL bp_acc_data[%0d] got=%0d want=30", i, acc_data); end
            nCompared++; if (prod_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_prod_ready[%0d] got=%b want=0", i, prod_ready); end
            tick();
        end
        start = 1'b0;
        nCompared++; if (term_cnt !== 5'd3) begin nMismatched++; $display("[TB] FAIL bp_term_cnt got=%0d want=3", term_cnt); end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL bp_release_busy got=%b want=0", busy); end
    endtask

    task automatic test_back_to_back();
        applyStimulus(1'b1, 5'd1, 1'b0, 12'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd1, 1'b1, 12'd9, 1'b0);
        tick();
        prod_valid = 1'b0;
        nCompared++; if (acc_data !== 16'd9) begin nMismatched++; $display("[TB] FAIL b2b_first_data got=%0d want=9", acc_data); end
        applyStimulus(1'b1, 5'd2, 1'b0, 12'd0, 1'b1);
        tick();
        applyStimulus(1'b0, 5'd2, 1'b1, 12'd7, 1'b0);
        nCompared++; if (prod_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_no_idle got=%b want=1", prod_ready); end
        nCompared++; if (acc_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL b2b_acc_valid got=%b want=0", acc_valid); end
        nCompared++; if (acc_data !== 16'd0) begin nMismatched++; $display("[TB] FAIL b2b_cleared got=%0d want=0", acc_data); end
        nCompared++; if (term_cnt !== 5'd0) begin nMismatched++; $display("[TB] FAIL b2b_cnt_cleared got=%0d want=0", term_cnt); end
        tick();
        prod_data = 12'd8;
        tick();
        prod_valid = 1'b0;
        nCompared++; if (acc_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL b2b_second_valid got=%b want=1", acc_valid); end
        nCompared++; if (acc_data !== 16'd15) begin nMismatched++; $display("[TB] FAIL b2b_second_data got=%0d want=15", acc_data); end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
    endtask

    task automatic test_illegal_len();
        applyStimulus(1'b1, 5'd0, 1'b0, 12'd0, 1'b0);
        tick();
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL len0_busy got=%b want=0", busy); end
        len = 5'd17;
        tick();
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL len17_busy got=%b want=0", busy); end
        len = 5'd16;
        tick();
        applyStimulus(1'b0, 5'd16, 1'b1, 12'd1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            tick();
        end
        prod_valid = 1'b0;
        nCompared++; if (acc_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL len16_valid got=%b want=1", acc_valid); end
        nCompared++; if (acc_data !== 16'd16) begin nMismatched++; $display("[TB] FAIL len16_data got=%0d want=16", acc_data); end
        nCompared++; if (term_cnt !== 5'd16) begin nMismatched++; $display("[TB] FAIL len16_term_cnt got=%0d want=16", term_cnt); end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
    endtask

    task automatic test_reset_mid_acc();
        applyStimulus(1'b1, 5'd4, 1'b0, 12'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd4, 1'b1, 12'd100, 1'b0);
        tick();
        tick();
        prod_valid = 1'b0;
        nCompared++; if (term_cnt !== 5'd2) begin nMismatched++; $display("[TB] FAIL mid_term_cnt got=%0d want=2", term_cnt); end
        #1;
        rst = 1'b1;
        #1;
        nCompared++; if (prod_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL async_prod_ready got=%b want=0", prod_ready); end
        nCompared++; if (acc_data !== 16'd0) begin nMismatched++; $display("[TB] FAIL async_acc_data got=%0d want=0", acc_data); end
        #1;
        rst = 1'b0;
        tick();
        nCompared++; if (acc_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_rst_acc_valid got=%b want=0", acc_valid); end
        nCompared++; if (prod_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_rst_prod_ready got=%b want=0", prod_ready); end
        nCompared++; if (term_cnt !== 5'd0) begin nMismatched++; $display("[TB] FAIL mid_rst_term_cnt got=%0d want=0", term_cnt); end
        nCompared++; if (busy !== 1'b0) begin nMismatched++; $display("[TB] FAIL mid_rst_busy got=%b want=0", busy); end
        applyStimulus(1'b1, 5'd1, 1'b0, 12'd0, 1'b0);
        tick();
        applyStimulus(1'b0, 5'd1, 1'b1, 12'd5, 1'b0);
        tick();
        prod_valid = 1'b0;
        nCompared++; if (acc_data !== 16'd5) begin nMismatched++; $display("[TB] FAIL fresh_acc_data got=%0d want=5", acc_data); end
        nCompared++; if (acc_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL fresh_acc_valid got=%b want=1", acc_valid); end
        acc_ready = 1'b1;
        tick();
        acc_ready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [11:0] expData;
`ifdef MUL_ACC_SAT_EN
        expData = 12'd4095;
`else
        expData = 12'd3842;
`endif
        nStart = 1'b1; nLen = 5'd2;
        tick();
        nStart = 1'b0; nProdValid = 1'b1; nProdData = 12'd3969;
        tick();
        tick();
        nProdValid = 1'b0;
        nCompared++; if (nAccValid !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_acc_valid got=%b want=1", nAccValid); end
        nCompared++; if (nAccData !== expData) begin nMismatched++; $display("[TB] FAIL ovf_acc_data got=%0d want=%0d", nAccData, expData); end
`ifdef MUL_ACC_SAT_EN
        nCompared++; if (nOvf !== 1'b1) begin nMismatched++; $display("[TB] FAIL ovf_flag got=%b want=1", nOvf); end
        nCompared++; if (ovf !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_wide_flag got=%b want=0", ovf); end
`endif
        nAccReady = 1'b1; nStart = 1'b1; nLen = 5'd1;
        tick();
        nAccReady = 1'b0; nStart = 1'b0; nProdValid = 1'b1; nProdData = 12'd1;
`ifdef MUL_ACC_SAT_EN
        nCompared++; if (nOvf !== 1'b0) begin nMismatched++; $display("[TB] FAIL ovf_cleared got=%b want=0", nOvf); end
`endif
        tick();
        nProdValid = 1'b0;
        nCompared++; if (nAccData !== 12'd1) begin nMismatched++; $display("[TB] FAIL ovf_next_data got=%0d want=1", nAccData); end
        nAccReady = 1'b1;
        tick();
        nAccReady = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before summary");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        test_reset();
        test_continuous();
        test_gaps_backpressure();
        test_back_to_back();
        test_illegal_len();
        test_reset_mid_acc();
        test_overflow();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
